// File: rtl/stopwatch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_seq_ctrl
//
// Sequencing controller for the stopwatch datapath. It takes debounced key
// pulses and the 1 ms tick and produces a saturating millisecond count, the
// value to show on the display, and a lap capture/hold schedule. Downstream
// logic only has to convert and display t_disp.
//
// Parameters:
//   T_MAX      saturation value of the ms counter (must fit in 20 bits)
//   HOLD_MS    number of ms ticks a captured lap stays on the display
//   LAP_DEPTH  lap history depth (power of two, at most 4 so that it fits
//              lap_count); only used when LAP_FIFO_EN is defined
//
// Configuration macro:
//   LAP_FIFO_EN  defined   -> LAP_DEPTH-entry circular lap history plus the
//                             VIEW state for stepping through it
//                undefined -> a single lap value; VIEW is never entered
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   time_1ms   in   one-cycle pulse per millisecond
//   key_start  in   run/stop toggle pulse
//   key_lap    in   lap capture / history step pulse
//   key_clr    in   clear pulse
//   t          out  live ms count (20 bits)
//   t_disp     out  value to display: live, lap or history entry (20 bits)
//   running    out  counting is enabled (RUN or HOLD)
//   ovf        out  sticky flag, t has reached T_MAX
//   lap_count  out  number of stored laps (3 bits)
// ---------------------------------------------------------------------------
module stopwatch_seq_ctrl #(
    parameter int T_MAX     = 999999,
    parameter int HOLD_MS   = 2000,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_1ms,
    input  logic        key_start,
    input  logic        key_lap,
    input  logic        key_clr,
    output logic [19:0] t,
    output logic [19:0] t_disp,
    output logic        running,
    output logic        ovf,
    output logic [2:0]  lap_count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HOLD,
        STOP,
        VIEW
    } state_t;

    localparam int          HW    = (HOLD_MS < 2) ? 1 : $clog2(HOLD_MS + 1);
    localparam logic [19:0] T_SAT = 20'(T_MAX);

    state_t          state;
    state_t          state_n;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_n;
    logic [19:0]     t_tick;
    logic [19:0]     t_n;
    logic [19:0]     disp_n;
    logic            ovf_n;
    logic            counting;
    logic            do_start;
    logic            do_lap;
    logic            do_clr;
    logic            capture;
    logic            clear_all;

`ifdef LAP_FIFO_EN
    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [19:0]   lap_buf [LAP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [2:0]    rd_ptr;
    logic [2:0]    rd_n;
    logic [PW-1:0] oldest_idx;
    logic [PW-1:0] next_idx;

    // When the buffer is full lap_count wraps to 0 in the low bits, so the
    // oldest entry is then the one the write pointer is about to overwrite.
    assign oldest_idx = wr_ptr - lap_count[PW-1:0];
    assign next_idx   = oldest_idx + rd_ptr[PW-1:0] + PW'(1);
`else
    // A zero-depth build stores nothing, otherwise one lap is remembered.
    localparam logic [2:0] SINGLE_LAP_CNT = (LAP_DEPTH >= 1) ? 3'd1 : 3'd0;
`endif

    // Key priority: clear beats start beats lap; losers are dropped.
    assign do_clr   = key_clr;
    assign do_start = key_start & ~key_clr;
    assign do_lap   = key_lap & ~key_start & ~key_clr;

    // The count only advances in RUN/HOLD, which is what makes a tick count
    // on a RUN->STOP press but not on a STOP->RUN press.
    assign counting = (state == RUN) || (state == HOLD);
    assign t_tick   = (counting && time_1ms && (t != T_SAT)) ? t + 20'd1 : t;

    // Next-state, next-output and side-effect decode.
    always_comb begin
        state_n   = state;
        t_n       = t_tick;
        disp_n    = t_tick;
        hold_n    = hold_cnt;
        capture   = 1'b0;
        clear_all = 1'b0;
`ifdef LAP_FIFO_EN
        rd_n      = rd_ptr;
`endif

        case (state)
            IDLE: begin
                if (do_start) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                if (do_start) begin
                    state_n = STOP;
                end else if (do_lap) begin
                    state_n = HOLD;
                    capture = 1'b1;
                    hold_n  = HW'(HOLD_MS);
                end
            end

            HOLD: begin
                // t_disp keeps the captured lap until something changes it.
                disp_n = t_disp;
                if (do_start) begin
                    state_n = STOP;
                    hold_n  = '0;
                    disp_n  = t_tick;
                end else if (do_lap) begin
                    capture = 1'b1;
                    hold_n  = HW'(HOLD_MS);
                    disp_n  = t_tick;
                end else if (time_1ms) begin
                    if (hold_cnt <= HW'(1)) begin
                        state_n = RUN;
                        hold_n  = '0;
                        disp_n  = t_tick;
                    end else begin
                        hold_n = hold_cnt - HW'(1);
                    end
                end
            end

            STOP: begin
                if (do_clr) begin
                    state_n   = IDLE;
                    clear_all = 1'b1;
                    t_n       = '0;
                    disp_n    = '0;
                end else if (do_start) begin
                    state_n = RUN;
`ifdef LAP_FIFO_EN
                end else if (do_lap && (lap_count != 3'd0)) begin
                    state_n = VIEW;
                    rd_n    = 3'd0;
                    disp_n  = lap_buf[oldest_idx];
`endif
                end
            end

`ifdef LAP_FIFO_EN
            VIEW: begin
                disp_n = t_disp;
                if (do_clr) begin
                    state_n   = IDLE;
                    clear_all = 1'b1;
                    t_n       = '0;
                    disp_n    = '0;
                    rd_n      = 3'd0;
                end else if (do_start) begin
                    state_n = RUN;
                    rd_n    = 3'd0;
                    disp_n  = t_tick;
                end else if (do_lap) begin
                    if ((rd_ptr + 3'd1) >= lap_count) begin
                        state_n = STOP;
                        rd_n    = 3'd0;
                        disp_n  = t_tick;
                    end else begin
                        rd_n   = rd_ptr + 3'd1;
                        disp_n = lap_buf[next_idx];
                    end
                end
            end
`endif

            default: begin
                state_n = IDLE;
                t_n     = '0;
                disp_n  = '0;
            end
        endcase

        ovf_n = clear_all ? 1'b0 : (ovf | (t_n == T_SAT));
    end

    // State and registered outputs; lap storage updates on capture/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            t_disp    <= '0;
            running   <= 1'b0;
            ovf       <= 1'b0;
            lap_count <= '0;
            hold_cnt  <= '0;
`ifdef LAP_FIFO_EN
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_buf[i] <= '0;
            end
`endif
        end else begin
            state    <= state_n;
            t        <= t_n;
            t_disp   <= disp_n;
            running  <= (state_n == RUN) || (state_n == HOLD);
            ovf      <= ovf_n;
            hold_cnt <= hold_n;
`ifdef LAP_FIFO_EN
            rd_ptr   <= rd_n;
            if (clear_all) begin
                lap_count <= '0;
                wr_ptr    <= '0;
                for (int i = 0; i < LAP_DEPTH; i++) begin
                    lap_buf[i] <= '0;
                end
            end else if (capture) begin
                lap_buf[wr_ptr] <= t_tick;
                wr_ptr          <= wr_ptr + PW'(1);
                if (lap_count != 3'(LAP_DEPTH)) begin
                    lap_count <= lap_count + 3'd1;
                end
            end
`else
            // The single lap value itself lives in t_disp while in HOLD.
            if (clear_all) begin
                lap_count <= '0;
            end else if (capture) begin
                lap_count <= SINGLE_LAP_CNT;
            end
`endif
        end
    end

endmodule
